// File: rtl/mem_bus_pkg.sv
// Shared definitions for the stack-processor memory bus master.
// Holds the FSM encoding, the post-reset sync length and the detour address mask.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    ST_SYNC     = 3'd0,
    ST_IDLE     = 3'd1,
    ST_DET_LOW  = 3'd2,
    ST_DET_HIGH = 3'd3,
    ST_ACC_LOW  = 3'd4,
    ST_ACC_HIGH = 3'd5
  } state_e;

  localparam int SYNC_CYCLES = 3;
  localparam int DETOUR_MASK = 1;

  function automatic logic is_wait_state(input state_e s);
    return (s == ST_DET_LOW) || (s == ST_DET_HIGH) ||
           (s == ST_ACC_LOW) || (s == ST_ACC_HIGH);
  endfunction

endpackage

// File: rtl/mem_bus_master_phase_timer.sv
// Per-phase watchdog: clears on entry to a wait state, counts while waiting, saturates at TIMEOUT.
// o_done is registered-count based, so a timeout is acted on one edge after the count reaches TIMEOUT.
module phase_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          w_done;

  assign w_done = (r_cnt == CW'(TIMEOUT));
  assign o_done = w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !w_done) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mem_bus_master.sv
// Single-request memory bus master: load 3 edges / store 4 edges after acceptance, +3 on same-address detour.
// No response backpressure; req_ready is high only in IDLE, so the core stalls while an access is in flight.
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [DW-1:0] resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] addr,
  output logic          memory_w,
  output logic [DW-1:0] wdata,
  input  logic [DW-1:0] rdata,
  input  logic          memory_ready
);

  state_e        r_state, w_state_nxt;
  logic [AW-1:0] r_addr, w_addr_nxt;
  logic          r_mw, w_mw_nxt;
  logic [DW-1:0] r_wdata, w_wdata_nxt;
  logic [AW-1:0] r_lat_addr, w_lat_addr_nxt;
  logic          r_lat_we, w_lat_we_nxt;
  logic [DW-1:0] r_lat_wdata, w_lat_wdata_nxt;
  logic [AW-1:0] r_last_addr, w_last_addr_nxt;
  logic          r_resp_valid, w_resp_valid_nxt;
  logic          r_resp_err, w_resp_err_nxt;
  logic [DW-1:0] r_resp_rdata, w_resp_rdata_nxt;
  logic [1:0]    r_sync_cnt, w_sync_cnt_nxt;
  logic          w_timeout;
  logic          w_tmr_clr, w_tmr_en, w_tmr_done;

  // Entering any state (including LOW->HIGH) restarts the phase watchdog.
  assign w_tmr_clr = (w_state_nxt != r_state);
  assign w_tmr_en  = is_wait_state(r_state);

  phase_timer #(.TIMEOUT(TIMEOUT)) u_phase_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .o_done (w_tmr_done)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_nxt       = r_addr;
    w_mw_nxt         = r_mw;
    w_wdata_nxt      = r_wdata;
    w_lat_addr_nxt   = r_lat_addr;
    w_lat_we_nxt     = r_lat_we;
    w_lat_wdata_nxt  = r_lat_wdata;
    w_last_addr_nxt  = r_last_addr;
    w_resp_valid_nxt = 1'b0;
    w_resp_err_nxt   = r_resp_err;
    w_resp_rdata_nxt = r_resp_rdata;
    w_sync_cnt_nxt   = r_sync_cnt;
    w_timeout        = 1'b0;

    unique case (r_state)
      ST_SYNC: begin
        if (!memory_ready) begin
          w_sync_cnt_nxt = '0;
        end else if (r_sync_cnt == 2'(SYNC_CYCLES - 1)) begin
          w_sync_cnt_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_sync_cnt_nxt = r_sync_cnt + 2'd1;
        end
      end
      ST_IDLE: begin
        if (req_valid) begin
          w_lat_addr_nxt  = req_addr;
          w_lat_we_nxt    = req_we;
          w_lat_wdata_nxt = req_wdata;
          // The memory only starts on an address change, so a repeat address needs a detour read first.
          if (req_addr != r_last_addr) begin
            w_addr_nxt  = req_addr;
            w_mw_nxt    = req_we;
            w_wdata_nxt = req_wdata;
            w_state_nxt = ST_ACC_LOW;
          end else begin
            w_addr_nxt  = req_addr ^ AW'(DETOUR_MASK);
            w_mw_nxt    = 1'b0;
            w_state_nxt = ST_DET_LOW;
          end
        end
      end
      ST_DET_LOW: begin
        if (!memory_ready)   w_state_nxt = ST_DET_HIGH;
        else if (w_tmr_done) w_timeout   = 1'b1;
      end
      ST_DET_HIGH: begin
        if (memory_ready) begin
          w_addr_nxt  = r_lat_addr;
          w_mw_nxt    = r_lat_we;
          w_wdata_nxt = r_lat_wdata;
          w_state_nxt = ST_ACC_LOW;
        end else if (w_tmr_done) begin
          w_timeout = 1'b1;
        end
      end
      ST_ACC_LOW: begin
        if (!memory_ready)   w_state_nxt = ST_ACC_HIGH;
        else if (w_tmr_done) w_timeout   = 1'b1;
      end
      ST_ACC_HIGH: begin
        if (memory_ready) begin
          if (!r_lat_we) w_resp_rdata_nxt = rdata;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = 1'b0;
          w_last_addr_nxt  = r_addr;
          w_mw_nxt         = 1'b0;
          w_state_nxt      = ST_IDLE;
        end else if (w_tmr_done) begin
          w_timeout = 1'b1;
        end
      end
      default: w_state_nxt = ST_SYNC;
    endcase

    // A stalled memory may still be mid-cycle, so resynchronise before accepting more work.
    if (w_timeout) begin
      w_resp_valid_nxt = 1'b1;
      w_resp_err_nxt   = 1'b1;
      w_mw_nxt         = 1'b0;
      w_last_addr_nxt  = r_addr;
      w_sync_cnt_nxt   = '0;
      w_state_nxt      = ST_SYNC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SYNC;
      r_addr       <= '0;
      r_mw         <= 1'b0;
      r_wdata      <= '0;
      r_lat_addr   <= '0;
      r_lat_we     <= 1'b0;
      r_lat_wdata  <= '0;
      r_last_addr  <= '0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_sync_cnt   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr       <= w_addr_nxt;
      r_mw         <= w_mw_nxt;
      r_wdata      <= w_wdata_nxt;
      r_lat_addr   <= w_lat_addr_nxt;
      r_lat_we     <= w_lat_we_nxt;
      r_lat_wdata  <= w_lat_wdata_nxt;
      r_last_addr  <= w_last_addr_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_err   <= w_resp_err_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_sync_cnt   <= w_sync_cnt_nxt;
    end
  end

  assign req_ready  = (r_state == ST_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_err   = r_resp_err;
  assign resp_rdata = r_resp_rdata;
  assign addr       = r_addr;
  assign memory_w   = r_mw;
  assign wdata      = r_wdata;

endmodule

// File: tb/tb_mem_bus_master.sv
// Bench for mem_bus_master: behavioural memory that starts a cycle on address change,
// plus a transaction-level reference for latency, address trace and read data.
module tb_mem_bus_master;

  localparam int AW      = 16;
  localparam int DW      = 16;
  localparam int TIMEOUT = 15;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [AW-1:0] addr;
  logic          memory_w;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic          memory_ready = 1'b1;

  mem_bus_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .addr         (addr),
    .memory_w     (memory_w),
    .wdata        (wdata),
    .rdata        (rdata),
    .memory_ready (memory_ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [15:0] init_val(input int i);
    logic [31:0] v;
    v = i * 40503 + 4660;
    return v[15:0];
  endfunction

  // Memory: one low cycle for a read, two for a write; no reset, ignores changes while busy.
  logic [15:0] mem [0:255];
  logic        m_inited = 1'b0;
  logic        stuck = 1'b0;
  logic [15:0] m_prev = '0;
  logic [7:0]  m_addr = '0;
  logic        m_we = 1'b0;
  logic [15:0] m_wd = '0;
  int          m_busy = 0;

  always @(posedge clk) begin
    if (!m_inited) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      m_inited <= 1'b1;
    end
    if (stuck) begin
      memory_ready <= 1'b1;
      m_prev       <= addr;
      m_busy       <= 0;
    end else if (m_busy != 0) begin
      m_busy <= m_busy - 1;
      if (m_busy == 1) begin
        memory_ready <= 1'b1;
        if (m_we) mem[m_addr] <= m_wd;
        else      rdata       <= mem[m_addr];
      end
    end else if (addr != m_prev) begin
      m_prev       <= addr;
      m_addr       <= addr[7:0];
      m_we         <= memory_w;
      m_wd         <= wdata;
      memory_ready <= 1'b0;
      m_busy       <= memory_w ? 2 : 1;
    end
  end

  int ones;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)            ones <= 0;
    else if (memory_ready) ones <= ones + 1;
    else                   ones <= 0;
  end

  logic [15:0] ref_mem [0:255];
  logic [15:0] ref_last;
  logic [15:0] ref_last_rd;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_sync();
    int m;
    bit bad;
    m = 0;
    bad = 0;
    while (m < 40) begin
      @(negedge clk);
      if (req_ready !== (ones >= 3)) bad = 1;
      if (req_ready) break;
      m++;
    end
    chk("sync_ready_track", {31'd0, bad}, 32'd0);
    chk("sync_ones_at_ready", ones, 3);
  endtask

  task automatic do_req(input logic we, input logic [15:0] a, input logic [15:0] wd);
    int          n;
    int          exp_lat;
    bit          same;
    bit          mw_bad;
    bit          mw_seen;
    logic [15:0] exp_rd;
    logic [15:0] prev_a;
    logic [15:0] got;
    logic [15:0] trace[$];
    logic [15:0] exp_tr[$];
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_req", {31'd0, req_ready}, 32'd1);
    same    = (a == ref_last);
    exp_lat = (we ? 4 : 3) + (same ? 3 : 0) + 1;
    exp_rd  = we ? ref_last_rd : ref_mem[a[7:0]];
    if (same) exp_tr = '{a ^ 16'h0001, a};
    else      exp_tr = '{a};
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    prev_a    = addr;
    @(negedge clk);
    req_valid = 1'b0;
    n       = 1;
    mw_bad  = 0;
    mw_seen = 0;
    while (n < 60) begin
      if (addr != prev_a) begin
        trace.push_back(addr);
        prev_a = addr;
      end
      if (memory_w) begin
        mw_seen = 1;
        if (!we || addr != a || wdata != wd) mw_bad = 1;
      end
      if (resp_valid) break;
      @(negedge clk);
      n++;
    end
    chk("latency", n, exp_lat);
    chk("resp_err", {31'd0, resp_err}, 32'd0);
    chk("resp_rdata", {16'd0, resp_rdata}, {16'd0, exp_rd});
    chk("ready_in_resp", {31'd0, req_ready}, 32'd1);
    chk("mw_cleared", {31'd0, memory_w}, 32'd0);
    chk("mw_bad", {31'd0, mw_bad}, 32'd0);
    chk("mw_seen", {31'd0, mw_seen}, {31'd0, we});
    chk("trace_len", trace.size(), exp_tr.size());
    for (int i = 0; i < exp_tr.size(); i++) begin
      got = (i < trace.size()) ? trace[i] : 16'hDEAD;
      chk("trace_addr", {16'd0, got}, {16'd0, exp_tr[i]});
    end
    if (we) ref_mem[a[7:0]] = wd;
    else    ref_last_rd = exp_rd;
    ref_last = a;
  endtask

  initial begin
    int          n;
    int          m;
    logic [15:0] wd;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    ref_last    = '0;
    ref_last_rd = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_addr", {16'd0, addr}, 32'd0);
    chk("rst_mw", {31'd0, memory_w}, 32'd0);
    chk("rst_wdata", {16'd0, wdata}, 32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_rdata", {16'd0, resp_rdata}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_sync();

    do_req(1'b0, 16'h0010, 16'h0000);
    do_req(1'b1, 16'h0020, 16'hBEEF);
    do_req(1'b0, 16'h0021, 16'h0000);
    do_req(1'b0, 16'h0030, 16'h0000);
    do_req(1'b0, 16'h0030, 16'h0000);
    do_req(1'b0, 16'h0020, 16'h0000);

    // Memory never acknowledges: watchdog error then resync.
    stuck = 1'b1;
    chk("to_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h0040;
    @(negedge clk);
    req_valid = 1'b0;
    n = 1;
    while (!resp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("to_latency", n, TIMEOUT + 2);
    chk("to_err", {31'd0, resp_err}, 32'd1);
    chk("to_mw", {31'd0, memory_w}, 32'd0);
    chk("to_ready_resp", {31'd0, req_ready}, 32'd0);
    chk("to_rdata_kept", {16'd0, resp_rdata}, {16'd0, ref_last_rd});
    m = 0;
    while (!req_ready && m < 20) begin
      @(negedge clk);
      m++;
      if (m == 1) chk("to_pulse_one_cycle", {31'd0, resp_valid}, 32'd0);
    end
    chk("to_sync_cycles", m, 3);
    stuck = 1'b0;
    ref_last = 16'h0040;
    do_req(1'b0, 16'h0040, 16'h0000);

    // Reset in the middle of a store.
    wd = 16'h5A5A;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0050; req_wdata = wd;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", {16'd0, addr}, 32'd0);
    chk("mid_rst_mw", {31'd0, memory_w}, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    chk("mid_rst_resp", {31'd0, resp_valid}, 32'd0);
    ref_mem[8'h50] = wd;
    ref_last    = '0;
    ref_last_rd = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wait_sync();
    do_req(1'b0, 16'h0000, 16'h0000);
    do_req(1'b0, 16'h0050, 16'h0000);

    for (int k = 0; k < 24; k++) begin
      do_req(1'($urandom_range(0, 1)), 16'($urandom_range(0, 3)), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
